data_mem_stage: RTL
===================

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the internal data memory (power of two, 4..1024).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream (ALU stage) presents an operation this cycle.
REQ-005 in_ready  output  1  stage accepts the operation; transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 alu_result  input  32  byte address for loads/stores; pass-through result otherwise.
REQ-007 store_data  input  32  write data (register file read_data2).
REQ-008 MemRead, MemWrite, MemtoReg, RegWrite  input  1 each  control signals; MemRead && MemWrite together is illegal.
REQ-009 write_reg  input  5  destination register number.
REQ-010 out_valid  output  1  writeback bundle valid.
REQ-011 out_ready  input  1  writeback consumer accepts; transfer when out_valid && out_ready.
REQ-012 wb_data  output  32  MemtoReg ? loaded word : alu_result.
REQ-013 wb_reg  output  5  registered write_reg.
REQ-014 wb_RegWrite  output  1  registered RegWrite, forced 0 on fault.
REQ-015 fault  output  1  registered; high with out_valid when the accepted access faulted.
REQ-016 access_count  output  16  number of completed memory accesses (loads plus stores), saturating.

Function
REQ-017 FSM states: IDLE, LOAD, HOLD; reset state IDLE.
REQ-018 in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-019 Accept in IDLE, non-load op: store executes at that edge; output register loads; next state IDLE; latency 1 cycle to out_valid.
REQ-020 Accept in IDLE, load (MemRead=1, no fault): memory read issued; next state LOAD; next edge captures the read word into the output register, out_valid=1, next state IDLE; latency 2 cycles.
REQ-021 In LOAD with out_valid=1 and out_ready=0 (previous result still pending): the read word is held in a side register, next state HOLD; HOLD moves it to the output register on out_ready=1, then IDLE.
REQ-022 out_valid, wb_data, wb_reg, wb_RegWrite and fault are stable while out_valid && !out_ready; out_valid clears on transfer unless a new result loads in the same cycle.
REQ-023 Word index = alu_result[log2(DEPTH)+1:2].
REQ-024 Fault when (MemRead || MemWrite) and (alu_result[1:0] != 0, or any bit above log2(DEPTH)+1 set, or MemRead && MemWrite); on fault the memory is not written, the op completes with 1-cycle latency, fault=1, wb_RegWrite=0, wb_data=alu_result.
REQ-025 Non-memory op (MemRead=MemWrite=0): wb_data = alu_result regardless of MemtoReg; fault=0.
REQ-026 Store followed immediately by a load to the same word returns the newly stored data.
REQ-027 access_count increments by 1 per non-faulting load or store, at the completion edge; it holds at 16'hFFFF.

Reset
REQ-028 Asynchronous assertion: state=IDLE, out_valid=0, wb_data=0, wb_reg=0, wb_RegWrite=0, fault=0, access_count=0, side register cleared.
REQ-029 Reset during LOAD or HOLD abandons the load with no output; a store accepted before reset remains in memory.
REQ-030 Memory array contents are not reset.

Structure
REQ-031 Shared package holds the FSM state enumeration, DATA_W=32, REG_W=5 and the default DEPTH.
REQ-032 Memory array is the sub-module data_ram (synchronous write, registered read, one port).

Verification
REQ-033 Store alu_result=0x10, store_data=0xDEADBEEF, then load 0x10 with MemtoReg=1, write_reg=8, out_ready=1 -> wb_data=0xDEADBEEF, wb_reg=8, wb_RegWrite=1, 2 cycles after acceptance; access_count=2.
REQ-034 R-type op, alu_result=0x1234, RegWrite=1 -> out_valid after 1 cycle, wb_data=0x1234, fault=0, access_count unchanged.
REQ-035 Load from 0x13 (misaligned) and from 0x100 with DEPTH=64 (out of range) -> fault=1, wb_RegWrite=0, memory unchanged, access_count unchanged.
REQ-036 out_ready=0 for 5 cycles while loading 0x20 behind a pending result -> state HOLD, in_ready=0, outputs stable; on out_ready=1 the pending result is transferred first and the load result follows in the next cycle.
REQ-037 rst_n asserted low mid-LOAD -> out_valid=0 immediately; after release, a reload of the previously stored word returns the stored value.
REQ-038 Store issued back-to-back with a load to the same word 0x40 (0x0 stored, then 0xA5A5A5A5 stored, then loaded) -> load returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_stage_pkg.sv
// Shared types and constants for the data memory pipeline stage.
package data_mem_stage_pkg;
  localparam int DATA_W        = 32;
  localparam int REG_W         = 5;
  localparam int CNT_W         = 16;
  localparam int DEPTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/data_mem_stage_if.sv
// Upstream operation and writeback channels of the data memory stage.
interface data_mem_stage_if;
  import data_mem_stage_pkg::*;

  // Both channels: a beat transfers on a rising edge where valid && ready;
  // valid must not depend on ready, and payload is held while valid && !ready.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic              MemRead;
  logic              MemWrite;
  logic              MemtoReg;
  logic              RegWrite;
  logic [REG_W-1:0]  write_reg;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_reg;
  logic              wb_RegWrite;
  logic              fault;

  modport master (
    output in_valid, alu_result, store_data, MemRead, MemWrite, MemtoReg,
           RegWrite, write_reg, out_ready,
    input  in_ready, out_valid, wb_data, wb_reg, wb_RegWrite, fault
  );

  modport slave (
    input  in_valid, alu_result, store_data, MemRead, MemWrite, MemtoReg,
           RegWrite, write_reg, out_ready,
    output in_ready, out_valid, wb_data, wb_reg, wb_RegWrite, fault
  );
endinterface

// File: rtl/data_mem_stage_data_ram.sv
// Single-port word RAM: synchronous write, registered read, contents not reset.
module data_ram
  import data_mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only updates on a read so a returning load word survives a later write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/data_mem_stage.sv
// MEM stage: executes loads/stores against a local RAM and registers the writeback bundle.
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_stage_if.slave  bus,
  output logic [CNT_W-1:0] access_count,
  output state_t           dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] HI_MASK = {DATA_W{1'b1}} << (AW + 2);

  state_t state, state_n;

  logic              accept, mem_op, addr_fault, do_load, do_store, out_free;
  logic              ld_imm, ld_out, ld_side, hold_out;
  logic [DATA_W-1:0] ram_rdata, load_value;

  logic              out_valid_q, wb_regwrite_q, fault_q;
  logic [DATA_W-1:0] wb_data_q, side_data;
  logic [REG_W-1:0]  wb_reg_q;

  logic [REG_W-1:0]  p_reg;
  logic              p_regwrite, p_memtoreg;
  logic [DATA_W-1:0] p_alu;

  assign out_free     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state == ST_IDLE) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;

  assign mem_op     = bus.MemRead || bus.MemWrite;
  assign addr_fault = mem_op && ((bus.alu_result[1:0] != 2'b00) ||
                                 ((bus.alu_result & HI_MASK) != '0) ||
                                 (bus.MemRead && bus.MemWrite));
  assign do_load    = accept && bus.MemRead  && !addr_fault;
  assign do_store   = accept && bus.MemWrite && !addr_fault;
  assign load_value = p_memtoreg ? ram_rdata : p_alu;

  data_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (do_load || do_store),
    .we    (do_store),
    .addr  (bus.alu_result[AW+1:2]),
    .wdata (bus.store_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // HOLD parks the returning read word if the output register is still occupied.
  always_comb begin
    state_n  = state;
    ld_imm   = 1'b0;
    ld_out   = 1'b0;
    ld_side  = 1'b0;
    hold_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (do_load)     state_n = ST_LOAD;
        else if (accept) ld_imm  = 1'b1;
      end
      ST_LOAD: begin
        if (out_free) begin
          ld_out  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          ld_side = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          hold_out = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg      <= '0;
      p_regwrite <= 1'b0;
      p_memtoreg <= 1'b0;
      p_alu      <= '0;
      side_data  <= '0;
    end else begin
      if (do_load) begin
        p_reg      <= bus.write_reg;
        p_regwrite <= bus.RegWrite;
        p_memtoreg <= bus.MemtoReg;
        p_alu      <= bus.alu_result;
      end
      if (ld_side) side_data <= load_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      wb_data_q     <= '0;
      wb_reg_q      <= '0;
      wb_regwrite_q <= 1'b0;
      fault_q       <= 1'b0;
    end else if (ld_imm) begin
      // Non-loads and faulting accesses both report alu_result.
      out_valid_q   <= 1'b1;
      wb_data_q     <= bus.alu_result;
      wb_reg_q      <= bus.write_reg;
      wb_regwrite_q <= bus.RegWrite && !addr_fault;
      fault_q       <= addr_fault;
    end else if (ld_out || hold_out) begin
      out_valid_q   <= 1'b1;
      wb_data_q     <= ld_out ? load_value : side_data;
      wb_reg_q      <= p_reg;
      wb_regwrite_q <= p_regwrite;
      fault_q       <= 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_count <= '0;
    end else if ((do_store || ld_out || ld_side) && (access_count != '1)) begin
      access_count <= access_count + CNT_W'(1);
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.wb_RegWrite = wb_regwrite_q;
  assign bus.fault       = fault_q;
  assign dbg_state       = state;
endmodule
